// File: rtl/fb_pixel_writer.sv
// Frame-buffer write stage: linearises (x, y) pixels into SRAM word addresses,
// queues them in a small FIFO and swaps double-buffer offsets during vertical blank.
module fb_pixel_writer #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [23:0] pix_rgb,
    input  logic        pix_last,
    input  logic        swap_ok,
    output logic        sram_wr_en,
    input  logic        sram_wr_ready,
    output logic [18:0] sram_wr_addr,
    output logic [31:0] sram_wr_data,
    output logic        wr_addr_offset,
    output logic        rd_addr_offset,
    output logic        frame_done,
    output logic [15:0] drop_cnt
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DRAIN     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [50:0]   mem_q [DEPTH];
    logic [PW:0]   wptr_q, wptr_d;
    logic [PW:0]   rptr_q, rptr_d;
    logic          wr_off_q, wr_off_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   drop_q, drop_d;

    logic          fifo_empty, fifo_full;
    logic          hs, in_range, push, pop;
    logic [18:0]   lin_addr;
    logic [50:0]   head;

    // Extra pointer bit separates the full case from the empty case.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    assign pix_ready = (state_q == FILL) && !fifo_full;
    assign hs        = pix_valid && pix_ready;
    assign in_range  = (pix_x < 10'(WIDTH)) && (pix_y < 10'(HEIGHT));
    assign push      = hs && in_range;
    assign pop       = !fifo_empty && sram_wr_ready;
    assign lin_addr  = 19'(pix_y) * 19'(WIDTH) + 19'(pix_x);

    assign head           = mem_q[rptr_q[PW-1:0]];
    assign sram_wr_en     = !fifo_empty;
    assign sram_wr_addr   = head[50:32];
    assign sram_wr_data   = head[31:0];
    assign wr_addr_offset = wr_off_q;
    assign rd_addr_offset = !wr_off_q;
    assign frame_done     = frame_done_q;
    assign drop_cnt       = drop_q;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q + (push ? 1'b1 : 1'b0);
        rptr_d       = rptr_q + (pop ? 1'b1 : 1'b0);
        wr_off_d     = wr_off_q;
        frame_done_d = 1'b0;
        drop_d       = drop_q;

        if (hs && !in_range && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;

        case (state_q)
            FILL: begin
                if (hs && pix_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                // Judged on post-pop occupancy so the final pop moves on immediately.
                if (wptr_d == rptr_d)
                    state_d = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (swap_ok) begin
                    state_d      = FILL;
                    wr_off_d     = !wr_off_q;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            wptr_q       <= '0;
            rptr_q       <= '0;
            wr_off_q     <= 1'b1;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            wr_off_q     <= wr_off_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
            if (push)
                mem_q[wptr_q[PW-1:0]] <= {lin_addr, 8'h00, pix_rgb};
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: addressing, backpressure, drops, frame swap, reset.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        pix_last;
    logic        swap_ok;
    logic        sram_wr_en;
    logic        sram_wr_ready;
    logic [18:0] sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic        wr_addr_offset;
    logic        rd_addr_offset;
    logic        frame_done;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [50:0] wq[$];

    fb_pixel_writer #(.WIDTH(800), .HEIGHT(600), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_last(pix_last),
        .swap_ok(swap_ok),
        .sram_wr_en(sram_wr_en), .sram_wr_ready(sram_wr_ready),
        .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .wr_addr_offset(wr_addr_offset), .rd_addr_offset(rd_addr_offset),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every completed SRAM write, sampled mid-cycle.
    always @(negedge clk)
        if (reset_n && sram_wr_en && sram_wr_ready)
            wq.push_back({sram_wr_addr, sram_wr_data});

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y,
                        input logic [23:0] rgb, input logic last);
        int n = 0;
        pix_x = x; pix_y = y; pix_rgb = rgb; pix_last = last; pix_valid = 1'b1;
        while (!pix_ready && n < 50) begin cyc(); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout x=%0d y=%0d pix_ready stuck at 0, required 1", x, y);
        end
        cyc();
        pix_valid = 1'b0; pix_last = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_pix_ready got %0b exp 1", pix_ready); end
        checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %0b exp 0", sram_wr_en); end
        checks++; if (sram_wr_addr !== 19'd0) begin errors++; $display("FAIL rst_addr got %0h exp 0", sram_wr_addr); end
        checks++; if (sram_wr_data !== 32'd0) begin errors++; $display("FAIL rst_data got %0h exp 0", sram_wr_data); end
        checks++; if (wr_addr_offset !== 1'b1) begin errors++; $display("FAIL rst_wr_off got %0b exp 1", wr_addr_offset); end
        checks++; if (rd_addr_offset !== 1'b0) begin errors++; $display("FAIL rst_rd_off got %0b exp 0", rd_addr_offset); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0b exp 0", frame_done); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_basic();
        sram_wr_ready = 1'b1;
        send(10'd0, 10'd0, 24'h112233, 1'b0);
        checks++; if (sram_wr_en !== 1'b1) begin errors++; $display("FAIL basic_en got %0b exp 1", sram_wr_en); end
        checks++; if (sram_wr_addr !== 19'd0) begin errors++; $display("FAIL basic_addr got %0d exp 0", sram_wr_addr); end
        checks++; if (sram_wr_data !== 32'h00112233) begin errors++; $display("FAIL basic_data got %0h exp 00112233", sram_wr_data); end
        cyc();
        checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL basic_popped got %0b exp 0", sram_wr_en); end
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL basic_write_count got %0d exp 1", wq.size()); end
        wq.delete();
    endtask

    task automatic test_addr();
        sram_wr_ready = 1'b1;
        send(10'd799, 10'd599, 24'hFFFFFF, 1'b0);
        checks++; if (sram_wr_addr !== 19'd479999) begin errors++; $display("FAIL addr_max got %0d exp 479999", sram_wr_addr); end
        checks++; if (sram_wr_data !== 32'h00FFFFFF) begin errors++; $display("FAIL data_max got %0h exp 00ffffff", sram_wr_data); end
        send(10'd3, 10'd2, 24'h0A0B0C, 1'b0);
        checks++; if (sram_wr_addr !== 19'd1603) begin errors++; $display("FAIL addr_3_2 got %0d exp 1603", sram_wr_addr); end
        cyc();
        checks++; if (wq.size() != 2) begin errors++; $display("FAIL addr_write_count got %0d exp 2", wq.size()); end
        wq.delete();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        sram_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10'(10 + i), 10'd1, 24'hA00000 + 24'(i), 1'b0);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", pix_ready); end
        checks++; if (sram_wr_en !== 1'b1 || sram_wr_addr !== 19'd810) begin errors++; $display("FAIL bp_head got en=%0b addr=%0d exp en=1 addr=810", sram_wr_en, sram_wr_addr); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL bp_no_write got %0d exp 0", wq.size()); end
        sram_wr_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(10'(10 + i), 10'd1, 24'hA00000 + 24'(i), 1'b0);
        while (sram_wr_en && n < 20) begin cyc(); n++; end
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL bp_write_count got %0d exp 8", wq.size()); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== {19'(810 + i), 8'h00, 24'hA00000 + 24'(i)})
                begin errors++; $display("FAIL bp_order[%0d] got %0h exp addr=%0d data=%0h", i, wq[i], 810 + i, 24'hA00000 + 24'(i)); end
        end
        wq.delete();
    endtask

    task automatic test_drop();
        sram_wr_ready = 1'b1;
        send(10'd800, 10'd0, 24'h123456, 1'b0);
        send(10'd0, 10'd600, 24'h654321, 1'b0);
        cyc(); cyc();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL drop_no_write got %0d exp 0", wq.size()); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d exp 2", drop_cnt); end
        sram_wr_ready = 1'b0;
        swap_ok = 1'b1;
        send(10'd0, 10'd0, 24'h445566, 1'b1);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %0b exp 0", pix_ready); end
        repeat (5) cyc();
        checks++; if (sram_wr_en !== 1'b1) begin errors++; $display("FAIL drain_hold_en got %0b exp 1", sram_wr_en); end
        checks++; if (wr_addr_offset !== 1'b1) begin errors++; $display("FAIL drain_ignores_swap got %0b exp 1", wr_addr_offset); end
        sram_wr_ready = 1'b1;
        cyc();
        checks++; if (sram_wr_en !== 1'b0 || wr_addr_offset !== 1'b1 || frame_done !== 1'b0)
            begin errors++; $display("FAIL last_pop got en=%0b wr=%0b fd=%0b exp 0/1/0", sram_wr_en, wr_addr_offset, frame_done); end
        cyc();
        checks++; if (wr_addr_offset !== 1'b0 || rd_addr_offset !== 1'b1)
            begin errors++; $display("FAIL swap1_offsets got wr=%0b rd=%0b exp wr=0 rd=1", wr_addr_offset, rd_addr_offset); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL swap1_frame_done got %0b exp 1", frame_done); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL swap1_ready got %0b exp 1", pix_ready); end
        swap_ok = 1'b0;
        cyc();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL swap1_pulse_end got %0b exp 0", frame_done); end
        wq.delete();
    endtask

    task automatic test_swap_wait();
        sram_wr_ready = 1'b1;
        swap_ok = 1'b0;
        send(10'd5, 10'd5, 24'h010203, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (pix_ready !== 1'b0 || wr_addr_offset !== 1'b0 || frame_done !== 1'b0)
                begin errors++; $display("FAIL swap_wait[%0d] got ready=%0b wr=%0b fd=%0b exp 0/0/0", i, pix_ready, wr_addr_offset, frame_done); end
        end
        checks++; if (wq.size() != 1 || wq[0] !== {19'd4005, 32'h00010203})
            begin errors++; $display("FAIL swap_wait_write got n=%0d exp one write addr 4005", wq.size()); end
        swap_ok = 1'b1;
        cyc();
        checks++; if (wr_addr_offset !== 1'b1 || rd_addr_offset !== 1'b0 || frame_done !== 1'b1)
            begin errors++; $display("FAIL swap2 got wr=%0b rd=%0b fd=%0b exp 1/0/1", wr_addr_offset, rd_addr_offset, frame_done); end
        swap_ok = 1'b0;
        cyc();
        checks++; if (frame_done !== 1'b0 || pix_ready !== 1'b1)
            begin errors++; $display("FAIL swap2_after got fd=%0b ready=%0b exp 0/1", frame_done, pix_ready); end
        wq.delete();
    endtask

    task automatic test_reset_mid();
        sram_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(10'(20 + i), 10'd3, 24'h777777, 1'b0);
        checks++; if (sram_wr_en !== 1'b1) begin errors++; $display("FAIL mid_queued got %0b exp 1", sram_wr_en); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %0b exp 0", sram_wr_en); end
        checks++; if (wr_addr_offset !== 1'b1 || rd_addr_offset !== 1'b0)
            begin errors++; $display("FAIL mid_rst_offsets got wr=%0b rd=%0b exp 1/0", wr_addr_offset, rd_addr_offset); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_drop got %0d exp 0", drop_cnt); end
        cyc();
        reset_n = 1'b1;
        sram_wr_ready = 1'b1;
        cyc(); cyc();
        checks++; if (sram_wr_en !== 1'b0 || pix_ready !== 1'b1 || wq.size() != 0)
            begin errors++; $display("FAIL mid_after_rst got en=%0b ready=%0b writes=%0d exp 0/1/0", sram_wr_en, pix_ready, wq.size()); end
    endtask

    initial begin
        reset_n = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0; pix_last = 1'b0;
        swap_ok = 1'b0; sram_wr_ready = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        test_reset();
        test_basic();
        test_addr();
        test_back_to_back();
        test_drop();
        test_swap_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
